// File: rtl/axicb_wch_router.sv
// W-channel ordering stage: logs the granted master on each AW handshake and
// routes write-data beats only from the master at the head of that log.
module axicb_wch_router #(
  parameter int MST_NB      = 4,
  parameter int WCH_W       = 8,
  parameter int OSTDREQ_NUM = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  input  logic [MST_NB-1:0]       aw_grant,
  input  logic                    aw_hs,
  output logic                    aw_full,
  output logic                    empty,
  input  logic [MST_NB-1:0]       i_wvalid,
  output logic [MST_NB-1:0]       i_wready,
  input  logic [MST_NB-1:0]       i_wlast,
  input  logic [MST_NB*WCH_W-1:0] i_wch,
  output logic                    o_wvalid,
  input  logic                    o_wready,
  output logic                    o_wlast,
  output logic [WCH_W-1:0]        o_wch
);

  localparam int IDX_W = (MST_NB > 1) ? $clog2(MST_NB) : 1;
  localparam int PTR_W = $clog2(OSTDREQ_NUM);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] mem_q [OSTDREQ_NUM];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] head;
  logic             push;
  logic             pop;

  assign aw_full = (cnt_q == CNT_W'(OSTDREQ_NUM));
  assign empty   = (cnt_q == '0);
  assign push    = aw_hs & ~aw_full;
  assign pop     = o_wvalid & o_wready & o_wlast;
  assign head    = mem_q[rptr_q];

  // Lowest set grant bit wins, so a malformed multi-hot grant still logs one master.
  always_comb begin
    push_idx = '0;
    for (int k = MST_NB - 1; k >= 0; k--) begin
      if (aw_grant[k]) push_idx = IDX_W'(k);
    end
  end

  always_comb begin
    o_wvalid = 1'b0;
    o_wlast  = 1'b0;
    o_wch    = '0;
    i_wready = '0;
    if (!empty) begin
      o_wvalid       = i_wvalid[head];
      o_wlast        = i_wlast[head];
      o_wch          = i_wch[head*WCH_W +: WCH_W];
      i_wready[head] = o_wready;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (srst) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entries are only meaningful below count, so the storage itself needs no reset.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wptr_q] <= push_idx;
  end

endmodule

// File: tb/tb_axicb_wch_router.sv
// Randomized and directed bench for axicb_wch_router against a queue-based
// model of the AW order log.
module tb_axicb_wch_router;

  localparam int MST   = 4;
  localparam int WW    = 8;
  localparam int DEPTH = 4;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              srst;
  logic [MST-1:0]    aw_grant;
  logic              aw_hs;
  logic              aw_full;
  logic              empty;
  logic [MST-1:0]    i_wvalid;
  logic [MST-1:0]    i_wready;
  logic [MST-1:0]    i_wlast;
  logic [MST*WW-1:0] i_wch;
  logic              o_wvalid;
  logic              o_wready;
  logic              o_wlast;
  logic [WW-1:0]     o_wch;

  int checks = 0;
  int errors = 0;
  int illegal_cnt = 0;
  int order_q[$];

  always #5 aclk = ~aclk;

  axicb_wch_router #(.MST_NB(MST), .WCH_W(WW), .OSTDREQ_NUM(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .aw_grant(aw_grant), .aw_hs(aw_hs), .aw_full(aw_full), .empty(empty),
    .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
    .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch)
  );

  // Flags any AW handshake offered while the order log is full.
  always @(posedge aclk) begin
    if (aresetn && !srst && aw_hs && aw_full) illegal_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [MST-1:0] g);
    for (int k = 0; k < MST; k++) if (g[k]) return k;
    return 0;
  endfunction

  task automatic compare();
    logic [31:0] ev, el, ed, er;
    int h;
    ev = 0; el = 0; ed = 0; er = 0;
    if (order_q.size() > 0) begin
      h  = order_q[0];
      ev = 32'(i_wvalid[h]);
      el = 32'(i_wlast[h]);
      ed = 32'((i_wch >> (h*WW)) & 32'hFF);
      er = 32'(o_wready) << h;
    end
    chk("o_wvalid", 32'(o_wvalid), ev);
    chk("o_wlast",  32'(o_wlast),  el);
    chk("o_wch",    32'(o_wch),    ed);
    chk("i_wready", 32'(i_wready), er);
    chk("empty",    32'(empty),    32'(order_q.size() == 0));
    chk("aw_full",  32'(aw_full),  32'(order_q.size() == DEPTH));
  endtask

  task automatic model_update();
    bit do_pop, do_push;
    if (srst) begin
      order_q.delete();
    end else begin
      do_pop  = order_q.size() > 0 && i_wvalid[order_q[0]] && o_wready && i_wlast[order_q[0]];
      do_push = aw_hs && order_q.size() < DEPTH;
      if (do_pop)  void'(order_q.pop_front());
      if (do_push) order_q.push_back(lowest(aw_grant));
    end
  endtask

  task automatic cyc(input logic hs, input logic [MST-1:0] gnt, input logic [MST-1:0] wv,
                     input logic [MST-1:0] wl, input logic wr);
    aw_hs = hs; aw_grant = gnt; i_wvalid = wv; i_wlast = wl; o_wready = wr;
    i_wch = $urandom;
    @(negedge aclk);
    compare();
    model_update();
    @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && order_q.size() > 0; n++) cyc(0, 0, 4'hF, 4'hF, 1);
    chk("drained", 32'(order_q.size()), 0);
  endtask

  initial begin
    aresetn = 1'b0; srst = 1'b0; aw_hs = 0; aw_grant = 0;
    i_wvalid = 0; i_wlast = 0; i_wch = 0; o_wready = 0;
    #12;
    compare();
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Routing after AW log: master 2, four beats
    cyc(1, 4'b0100, 0, 0, 1);
    repeat (3) cyc(0, 0, 4'b0100, 0, 1);
    cyc(0, 0, 4'b0100, 4'b0100, 1);
    cyc(0, 0, 4'b0100, 0, 1);

    // W presented before its AW
    repeat (3) cyc(0, 0, 4'b0010, 0, 1);
    cyc(1, 4'b0010, 4'b0010, 0, 1);
    cyc(0, 0, 4'b0010, 0, 1);
    cyc(0, 0, 4'b0010, 4'b0010, 1);

    // Ordering m3, m0, m3 with both masters holding valid
    cyc(1, 4'b1000, 4'b1001, 0, 1);
    cyc(1, 4'b0001, 4'b1001, 0, 1);
    cyc(1, 4'b1000, 4'b1001, 4'b1001, 1);
    repeat (4) cyc(0, 0, 4'b1001, 4'b1001, 1);
    drain();

    // Full log, one refused handshake, then one burst frees a slot
    for (int k = 0; k < DEPTH; k++) cyc(1, 4'(1 << k), 0, 0, 1);
    cyc(1, 4'b0100, 0, 0, 1);
    chk("illegal_hs", 32'(illegal_cnt), 1);
    cyc(0, 0, 4'b0001, 4'b0001, 1);
    cyc(0, 0, 0, 0, 1);
    drain();

    // Push coinciding with the last beat under backpressure
    cyc(1, 4'b0010, 0, 0, 1);
    cyc(0, 0, 4'b0010, 0, 1);
    cyc(0, 0, 4'b0010, 4'b0010, 0);
    cyc(1, 4'b0100, 4'b0010, 4'b0010, 1);
    cyc(0, 0, 4'b0110, 4'b0100, 1);
    cyc(0, 0, 0, 0, 1);

    // Synchronous reset mid-burst
    cyc(1, 4'b1000, 0, 0, 1);
    repeat (2) cyc(0, 0, 4'b1000, 0, 1);
    srst = 1'b1;
    cyc(0, 0, 4'b1000, 0, 1);
    srst = 1'b0;
    cyc(0, 0, 4'b1000, 4'b1000, 1);

    // Asynchronous reset mid-burst, checked before any clock edge
    cyc(1, 4'b1000, 0, 0, 1);
    cyc(0, 0, 4'b1000, 0, 1);
    aw_hs = 0; i_wvalid = 4'b1000; o_wready = 1;
    aresetn = 1'b0;
    #2;
    order_q.delete();
    compare();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Randomized traffic; the switch side honours aw_full
    for (int n = 0; n < 2000; n++) begin
      logic hs;
      logic [MST-1:0] g;
      hs = ($urandom_range(0, 2) == 0) && order_q.size() < DEPTH;
      g  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'(1 << $urandom_range(0, MST-1));
      cyc(hs, g, 4'($urandom), 4'($urandom) & 4'($urandom), 1'($urandom));
    end
    drain();
    chk("illegal_final", 32'(illegal_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
